// File: rtl/get_max.sv
// Streams DATA_SIZE words from a 2-cycle-latency memory, copies each to an
// intermediate memory and reports the signed maximum. Define GET_MAX_ABS_EN to rank by magnitude instead.
module get_max #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int DATA_SIZE = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          get_max_start,
    output logic          get_max_ready,
    input  logic [DW-1:0] data_in,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_ena,
    output logic [DW-1:0] scale,
    input  logic          downstream_ready,
    output logic          get_max_done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_DS} state_t;

    localparam logic [AW-1:0] LAST = AW'(DATA_SIZE - 1);

    state_t                state;
    logic                  vld_p0, vld_p1;
    logic [AW-1:0]         addr_p0, addr_p1;
    logic signed [DW-1:0]  max_val;
    logic signed [DW-1:0]  key_p1;
    logic signed [DW-1:0]  next_max;

    // Ranking key: identity, or saturated magnitude when the abs feature is on.
    function automatic logic signed [DW-1:0] cmp_key(input logic signed [DW-1:0] d);
`ifdef GET_MAX_ABS_EN
        if (d == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        else if (d < 0)
            return -d;
        else
            return d;
`else
        return d;
`endif
    endfunction

    always_comb begin
        key_p1   = cmp_key(data_in);
        next_max = max_val;
        if (addr_p1 == '0 || key_p1 > max_val)
            next_max = key_p1;
    end

    assign get_max_ready = (state == IDLE);
    assign wr_ena        = vld_p1;
    assign wr_addr       = vld_p1 ? addr_p1 : '0;
    assign wr_data       = vld_p1 ? data_in : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_addr      <= '0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            addr_p0      <= '0;
            addr_p1      <= '0;
            max_val      <= '0;
            scale        <= '0;
            get_max_done <= 1'b0;
        end else begin
            // p0: address issued to memory; p1: its data is on data_in
            vld_p0  <= (state == READ);
            addr_p0 <= (state == READ) ? rd_addr : '0;
            vld_p1  <= vld_p0;
            addr_p1 <= addr_p0;
            if (vld_p1)
                max_val <= next_max;

            case (state)
                IDLE: begin
                    if (get_max_start) begin
                        state   <= READ;
                        rd_addr <= '0;
                    end
                end
                READ: begin
                    if (rd_addr == LAST) begin
                        state   <= DRAIN;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last word arriving: result may go out on the very next cycle.
                    if (vld_p1 && addr_p1 == LAST) begin
                        state <= WAIT_DS;
                        if (downstream_ready) begin
                            get_max_done <= 1'b1;
                            scale        <= next_max;
                        end
                    end
                end
                WAIT_DS: begin
                    if (get_max_done) begin
                        get_max_done <= 1'b0;
                        scale        <= '0;
                        state        <= IDLE;
                    end else if (downstream_ready) begin
                        get_max_done <= 1'b1;
                        scale        <= max_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_get_max.sv
// Bench for get_max: directed pattern table, stall/reset sequences and random runs
// against a plain-arithmetic maximum model backed by a 2-cycle-latency memory.
module tb_get_max;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DS = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          get_max_start = 1'b0;
    logic          get_max_ready;
    logic [DW-1:0] data_in = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_ena;
    logic [DW-1:0] scale;
    logic          downstream_ready = 1'b1;
    logic          get_max_done;

    get_max #(.AW(AW), .DW(DW), .DATA_SIZE(DS)) dut (
        .clk(clk), .rst(rst), .get_max_start(get_max_start), .get_max_ready(get_max_ready),
        .data_in(data_in), .rd_addr(rd_addr), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_ena(wr_ena), .scale(scale), .downstream_ready(downstream_ready),
        .get_max_done(get_max_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] addr_q = '0;
    int            cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            wi = 0;
    int            bad = 0;

    // Input memory: address registered, then data registered.
    always @(posedge clk) begin
        addr_q  <= rd_addr;
        data_in <= mem[addr_q];
        cyc     <= cyc + 1;
    end

    // Write-stream and idle-output monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_ena) begin
                if (int'(wr_addr) != wi || wr_data != mem[wi[AW-1:0]]) bad++;
                wi++;
            end else if (wr_addr != '0 || wr_data != '0) begin
                bad++;
            end
            if (!get_max_done && scale != '0) bad++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint key_of(input logic [DW-1:0] w);
        longint v;
        v = longint'($signed(w));
`ifdef GET_MAX_ABS_EN
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
`endif
        return v;
    endfunction

    function automatic logic [DW-1:0] model_max();
        longint best;
        best = key_of(mem[0]);
        for (int i = 1; i < DS; i++)
            if (key_of(mem[i]) > best) best = key_of(mem[i]);
        return best[DW-1:0];
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < DS; i++) begin
            case (pat)
                0: mem[i] = DW'(i);
                1: mem[i] = (i == 77) ? 32'hFFFF_FFFF : 32'hFFFF_FFFB;
                2: mem[i] = (i == 0) ? 32'h7FFF_FFFF : 32'h0;
                3: mem[i] = 32'h8000_0000;
                4: mem[i] = (i == 10) ? 32'hFFFF_FF38 : (i == 90) ? 32'd150 : 32'h0;
                default: mem[i] = (i == DS - 1) ? 32'd5 : 32'hFFFF_FFFF;
            endcase
        end
    endtask

    task automatic run_once(input int stall, input logic [DW-1:0] exp, input string name);
        int  k;
        int  t0;
        bit  early;
        downstream_ready = (stall == 0);
        k = 0;
        while (!get_max_ready && k < 300) begin @(negedge clk); k++; end
        wi  = 0;
        bad = 0;
        get_max_start = 1'b1;
        @(negedge clk);
        get_max_start = 1'b0;
        t0 = cyc;
        check({name, "_ready_low"}, 64'(get_max_ready), 64'd0);
        if (stall > 0) begin
            k = 0;
            while (wi < DS && k < DS + 20) begin @(negedge clk); k++; end
            early = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (get_max_done) early = 1'b1;
            end
            check({name, "_done_held"}, 64'(early), 64'd0);
            downstream_ready = 1'b1;
            @(negedge clk);
            check({name, "_done_after_ds"}, 64'(get_max_done), 64'd1);
        end else begin
            k = 0;
            while (!get_max_done && k < DS + 20) begin @(negedge clk); k++; end
            check({name, "_done_seen"}, 64'(get_max_done), 64'd1);
            check({name, "_latency"}, 64'(cyc - t0), 64'(DS + 2));
        end
        check({name, "_scale"}, 64'(scale), 64'(exp));
        @(negedge clk);
        check({name, "_done_1cyc"}, 64'(get_max_done), 64'd0);
        check({name, "_ready_back"}, 64'(get_max_ready), 64'd1);
        check({name, "_writes"}, 64'(wi), 64'(DS));
        check({name, "_stream_ok"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        int            pat;
        int            stall;
        int            gap;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  seen;
`ifdef GET_MAX_ABS_EN
        vecs[0] = '{0, 0, 0, 32'h0000_007F};
        vecs[1] = '{1, 0, 0, 32'h0000_0005};
        vecs[2] = '{2, 0, 0, 32'h7FFF_FFFF};
        vecs[3] = '{2, 0, 150, 32'h7FFF_FFFF};
        vecs[4] = '{3, 0, 0, 32'h7FFF_FFFF};
        vecs[5] = '{4, 0, 0, 32'h0000_00C8};
        vecs[6] = '{5, 20, 0, 32'h0000_0005};
        vecs[7] = '{0, 3, 0, 32'h0000_007F};
`else
        vecs[0] = '{0, 0, 0, 32'h0000_007F};
        vecs[1] = '{1, 0, 0, 32'hFFFF_FFFF};
        vecs[2] = '{2, 0, 0, 32'h7FFF_FFFF};
        vecs[3] = '{2, 0, 150, 32'h7FFF_FFFF};
        vecs[4] = '{3, 0, 0, 32'h8000_0000};
        vecs[5] = '{4, 0, 0, 32'h0000_0096};
        vecs[6] = '{5, 20, 0, 32'h0000_0005};
        vecs[7] = '{0, 3, 0, 32'h0000_007F};
`endif
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;

        #2 rst = 1'b1;
        #1;
        check("rst_ready", 64'(get_max_ready), 64'd1);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr", 64'({wr_ena, wr_addr, wr_data}), 64'd0);
        check("rst_done_scale", 64'({get_max_done, scale}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].pat);
            repeat (vecs[v].gap) @(negedge clk);
            run_once(vecs[v].stall, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Spurious starts during READ, then reset at rd_addr 50.
        fill(0);
        wi = 0;
        get_max_start = 1'b1;
        @(negedge clk);
        get_max_start = 1'b0;
        seen = 0;
        while (rd_addr != 12'd50 && seen < 200) begin
            if (rd_addr == 12'd10 || rd_addr == 12'd30) get_max_start = 1'b1;
            else get_max_start = 1'b0;
            @(negedge clk);
            seen++;
        end
        get_max_start = 1'b0;
        check("abort_reached_50", 64'(rd_addr), 64'd50);
        check("abort_no_restart", 64'(wi), 64'd48);
        rst = 1'b1;
        #1;
        check("abort_wr_ena", 64'(wr_ena), 64'd0);
        check("abort_ready", 64'(get_max_ready), 64'd1);
        check("abort_rd_addr", 64'(rd_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < DS + 20; c++) begin
            @(negedge clk);
            if (wr_ena || get_max_done) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);
        fill(3);
        run_once(0, vecs[4].exp, "post_abort");

        // Random runs against the model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DS; i++) begin
                if (r[0]) mem[i] = DW'($urandom_range(0, 40)) - 32'd20;
                else      mem[i] = $urandom;
            end
            run_once(int'($urandom_range(0, 3)), model_max(), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/get_max.md
GET_MAX -- requirements
Module: get_max

Interface
REQ-001 Parameter AW, default 12, address width of rd_addr and wr_addr.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 Parameter DATA_SIZE, default 128, number of words processed per run; SHALL satisfy 2 <= DATA_SIZE <= 2^AW.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; asynchronous and active-high.
REQ-006 get_max_start  in  1  one-cycle start pulse from upstream.
REQ-007 get_max_ready  out  1  high when idle and able to accept get_max_start.
REQ-008 data_in  in  DW  input-memory read data, valid two cycles after rd_addr.
REQ-009 rd_addr  out  AW  input-memory read address, registered.
REQ-010 wr_data  out  DW  intermediate-memory write data.
REQ-011 wr_addr  out  AW  intermediate-memory write address.
REQ-012 wr_ena  out  1  intermediate-memory write enable.
REQ-013 scale  out  DW  maximum of the run; valid only while get_max_done=1.
REQ-014 downstream_ready  in  1  downstream can accept the result.
REQ-015 get_max_done  out  1  one-cycle result pulse to downstream.

Function
REQ-016 States SHALL be IDLE, READ, DRAIN and WAIT_DS; get_max_ready=1 only in IDLE.
REQ-017 IDLE->READ on the edge where get_max_start=1; get_max_start outside IDLE SHALL be ignored.
REQ-018 In READ, rd_addr SHALL equal 0 in the first cycle and increment by 1 per cycle up to DATA_SIZE-1, then the state SHALL move to DRAIN.
REQ-019 Read latency is fixed at 2: data_in sampled at edge N+2 belongs to the rd_addr presented at edge N; a 2-stage valid/address pipeline SHALL track it.
REQ-020 For each returned word i: wr_ena=1, wr_addr=i, wr_data=data_in in the same cycle; otherwise wr_ena=0, wr_addr=0, wr_data=0.
REQ-021 Comparison SHALL be signed two's complement over DW bits; word 0 loads the running max unconditionally; each later word replaces it only if strictly greater.
REQ-022 DRAIN->WAIT_DS after the last (DATA_SIZE-1) word is written.
REQ-023 In WAIT_DS, when downstream_ready=1, get_max_done=1 and scale=final max for exactly one cycle, then return to IDLE; while downstream_ready=0 the block SHALL hold in WAIT_DS.
REQ-024 scale SHALL be 0 whenever get_max_done=0.
REQ-025 Timing for start sampled at edge 0 with downstream_ready=1: rd_addr=i in cycle i+1, write i in cycle i+3, get_max_done in cycle DATA_SIZE+3, get_max_ready high again in cycle DATA_SIZE+4.
REQ-026 A new get_max_start in the first IDLE cycle after done SHALL start a new run with the running max discarded.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, get_max_ready=1, rd_addr=0, wr_ena=0, wr_addr=0, wr_data=0, scale=0, get_max_done=0, running max=0, pipeline valids=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no further writes or done pulse.

Configuration
REQ-029 Macro GET_MAX_ABS_EN: when defined, comparison SHALL use absolute values (most negative value saturates to 2^(DW-1)-1) and scale reports the maximum magnitude; when undefined, signed comparison per REQ-021.

Verification
REQ-030 Ramp data 0..127, downstream_ready=1, start pulse -> 128 writes with wr_addr=wr_data=i, scale=0x0000007F with get_max_done exactly DATA_SIZE+3 cycles after start.
REQ-031 All words 0xFFFFFFFB except word 77=0xFFFFFFFF -> scale=0xFFFFFFFF (signed -1, not 0).
REQ-032 Max at word 0 (0x7FFFFFFF, rest 0) -> scale=0x7FFFFFFF; second start 1500 ns later on same data -> identical result.
REQ-033 downstream_ready=0 for 20 cycles after last write -> get_max_done stays 0, asserts one cycle after downstream_ready rises, with scale held.
REQ-034 Extra get_max_start pulses during READ, plus rst at rd_addr=50 -> starts ignored; after reset wr_ena=0, get_max_ready=1, no done pulse.
REQ-035 With GET_MAX_ABS_EN, data containing -200 and 150 -> scale=200 (0x000000C8).
